// File: rtl/seg7_scan_ctrl_if.sv
// Register port bundle for the seven-segment scan controller.
// The CPU side drives writes and an address; the controller returns combinational readback.
interface seg7_scan_ctrl_if;
   logic        wr_en;
   logic [1:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;

   modport master (output wr_en, output addr, output wr_data, input rd_data);
   modport slave  (input wr_en, input addr, input wr_data, output rd_data);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Six-digit multiplexed seven-segment controller with a memory-mapped register port.
// Each digit gets a blank interval followed by a dwell interval.
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS   = 6,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic             clk,
   input  logic             rst,
   seg7_scan_ctrl_if.slave  bus,
   output logic [7:0]       seg_data,
   output logic [5:0]       seg_sel
);

   localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [2:0]       IDX_LAST   = 3'(NUM_DIGITS - 1);

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   logic [23:0]      value_r;
   logic [5:0]       dp_r;
   logic [5:0]       en_r;
   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [2:0]       idx_r;
   logic [7:0]       next_data_s;
   logic [5:0]       next_sel_s;

   function automatic logic [7:0] hex_decode(input logic [3:0] nib);
      logic [7:0] glyph;
      case (nib)
         4'h0:    glyph = 8'hC0;
         4'h1:    glyph = 8'hF9;
         4'h2:    glyph = 8'hA4;
         4'h3:    glyph = 8'hB0;
         4'h4:    glyph = 8'h99;
         4'h5:    glyph = 8'h92;
         4'h6:    glyph = 8'h82;
         4'h7:    glyph = 8'hF8;
         4'h8:    glyph = 8'h80;
         4'h9:    glyph = 8'h90;
         4'hA:    glyph = 8'h88;
         4'hB:    glyph = 8'h83;
         4'hC:    glyph = 8'hC6;
         4'hD:    glyph = 8'hA1;
         4'hE:    glyph = 8'h86;
         4'hF:    glyph = 8'h8E;
         default: glyph = 8'hFF;
      endcase
      return glyph;
   endfunction

   function automatic logic [3:0] nibble_sel(input logic [23:0] val, input logic [2:0] idx);
      logic [3:0] nib;
      case (idx)
         3'd0:    nib = val[3:0];
         3'd1:    nib = val[7:4];
         3'd2:    nib = val[11:8];
         3'd3:    nib = val[15:12];
         3'd4:    nib = val[19:16];
         3'd5:    nib = val[23:20];
         default: nib = 4'h0;
      endcase
      return nib;
   endfunction

   function automatic logic bit_sel(input logic [5:0] bits, input logic [2:0] idx);
      logic b;
      case (idx)
         3'd0:    b = bits[0];
         3'd1:    b = bits[1];
         3'd2:    b = bits[2];
         3'd3:    b = bits[3];
         3'd4:    b = bits[4];
         3'd5:    b = bits[5];
         default: b = 1'b0;
      endcase
      return b;
   endfunction

   function automatic logic [5:0] one_cold(input logic [2:0] idx);
      logic [5:0] sel;
      case (idx)
         3'd0:    sel = 6'b111110;
         3'd1:    sel = 6'b111101;
         3'd2:    sel = 6'b111011;
         3'd3:    sel = 6'b110111;
         3'd4:    sel = 6'b101111;
         3'd5:    sel = 6'b011111;
         default: sel = 6'b111111;
      endcase
      return sel;
   endfunction

   // Register file writes; unused upper data bits are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_r <= 24'h000000;
         dp_r    <= 6'b000000;
         en_r    <= 6'b111111;
      end else if (bus.wr_en) begin
         case (bus.addr)
            2'd0:    value_r <= bus.wr_data[23:0];
            2'd1:    dp_r    <= bus.wr_data[5:0];
            2'd2:    en_r    <= bus.wr_data[5:0];
            default: ;
         endcase
      end
   end

   // Combinational readback of the selected register.
   always_comb begin
      bus.rd_data = 32'h0000_0000;
      case (bus.addr)
         2'd0:    bus.rd_data = {8'h00, value_r};
         2'd1:    bus.rd_data = {26'h0, dp_r};
         2'd2:    bus.rd_data = {26'h0, en_r};
         default: bus.rd_data = 32'h0000_0000;
      endcase
   end

   // Glyph and select for the current index, captured into the output registers at BLANK->DRIVE.
   always_comb begin
      next_data_s = 8'hFF;
      next_sel_s  = 6'h3F;
      if (bit_sel(en_r, idx_r)) begin
         next_data_s = hex_decode(nibble_sel(value_r, idx_r));
         next_data_s[7] = next_data_s[7] & ~bit_sel(dp_r, idx_r);
         next_sel_s  = one_cold(idx_r);
      end else begin
         next_data_s = 8'hFF;
         next_sel_s  = 6'h3F;
      end
   end

   // Scan FSM: outputs hold their latched value for the whole dwell so mid-dwell writes stay invisible.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_BLANK;
         cnt_r    <= '0;
         idx_r    <= 3'd0;
         seg_data <= 8'hFF;
         seg_sel  <= 6'h3F;
      end else begin
         case (state_r)
            ST_BLANK: begin
               if (cnt_r == BLANK_LAST) begin
                  state_r  <= ST_DRIVE;
                  cnt_r    <= '0;
                  seg_data <= next_data_s;
                  seg_sel  <= next_sel_s;
               end else begin
                  cnt_r    <= cnt_r + 1'b1;
                  seg_data <= 8'hFF;
                  seg_sel  <= 6'h3F;
               end
            end
            ST_DRIVE: begin
               if (cnt_r == SCAN_LAST) begin
                  state_r  <= ST_BLANK;
                  cnt_r    <= '0;
                  idx_r    <= (idx_r == IDX_LAST) ? 3'd0 : idx_r + 3'd1;
                  seg_data <= 8'hFF;
                  seg_sel  <= 6'h3F;
               end else begin
                  cnt_r    <= cnt_r + 1'b1;
               end
            end
            default: begin
               state_r  <= ST_BLANK;
               cnt_r    <= '0;
               idx_r    <= 3'd0;
               seg_data <= 8'hFF;
               seg_sel  <= 6'h3F;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench: timeline-based display model plus directed literal checks and random traffic.
module tb_seg7_scan_ctrl;
   localparam int SD = 4;
   localparam int BC = 2;
   localparam int P  = SD + BC;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg7_scan_ctrl_if bus();
   logic [7:0] seg_data;
   logic [5:0] seg_sel;

   seg7_scan_ctrl #(.NUM_DIGITS(6), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
      .clk(clk), .rst(rst), .bus(bus), .seg_data(seg_data), .seg_sel(seg_sel)
   );

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   logic [7:0] hex_tbl [16];
   logic [7:0] frame_tbl [6];

   // Model state: register shadows, cycles since last reset edge, expected outputs.
   logic [23:0] m_val = 24'h0;
   logic [5:0]  m_dp  = 6'h0;
   logic [5:0]  m_en  = 6'h3F;
   int          t     = 0;
   logic [5:0]  exp_sel  = 6'h3F;
   logic [7:0]  exp_data = 8'hFF;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] glyph_model(input int d);
      logic [23:0] sh;
      sh = m_val >> (4 * d);
      if (!m_en[d]) return 8'hFF;
      return hex_tbl[sh[3:0]] & (m_dp[d] ? 8'h7F : 8'hFF);
   endfunction

   function automatic logic [5:0] sel_model(input int d);
      logic [5:0] one;
      one = 6'd1;
      if (!m_en[d]) return 6'h3F;
      return ~(one << d);
   endfunction

   function automatic logic [31:0] rd_model(input logic [1:0] a);
      case (a)
         2'd0:    return {8'h00, m_val};
         2'd1:    return {26'h0, m_dp};
         2'd2:    return {26'h0, m_en};
         default: return 32'h0;
      endcase
   endfunction

   // Time t after a reset edge: phase t%P below BC is blank, otherwise digit (t/P)%6 shown as sampled at phase BC.
   always @(posedge clk) begin
      if (rst) begin
         m_val <= 24'h0; m_dp <= 6'h0; m_en <= 6'h3F; t <= 0;
         exp_sel <= 6'h3F; exp_data <= 8'hFF;
      end else begin
         t <= t + 1;
         if (((t + 1) % P) < BC) begin
            exp_sel <= 6'h3F; exp_data <= 8'hFF;
         end else if (((t + 1) % P) == BC) begin
            exp_sel  <= sel_model(((t + 1) / P) % 6);
            exp_data <= glyph_model(((t + 1) / P) % 6);
         end
         if (bus.wr_en) begin
            case (bus.addr)
               2'd0: m_val <= bus.wr_data[23:0];
               2'd1: m_dp  <= bus.wr_data[5:0];
               2'd2: m_en  <= bus.wr_data[5:0];
               default: ;
            endcase
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         check("seg_sel", {26'h0, seg_sel}, {26'h0, exp_sel});
         check("seg_data", {24'h0, seg_data}, {24'h0, exp_data});
         check("rd_data", bus.rd_data, rd_model(bus.addr));
      end
   end

   task automatic put(input logic en, input logic [1:0] a, input logic [31:0] d);
      bus.wr_en = en; bus.addr = a; bus.wr_data = d;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      put(1'b0, 2'd0, 32'h0);
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      hex_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      frame_tbl = '{8'hF9, 8'hB0, 8'h8E, 8'h92, 8'h88, 8'hC0};
      put(1'b0, 2'd0, 32'h0);
      do_reset(3);
      chk_on = 1'b1;

      // Reset/idle timeline.
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (n < 2 || n == 6 || n == 7) begin
            check("idle_blank_sel", {26'h0, seg_sel}, 32'h3F);
            check("idle_blank_data", {24'h0, seg_data}, 32'hFF);
         end else if (n < 6) begin
            check("idle_d0_sel", {26'h0, seg_sel}, 32'h3E);
            check("idle_d0_data", {24'h0, seg_data}, 32'hC0);
         end else begin
            check("idle_d1_sel", {26'h0, seg_sel}, 32'h3D);
         end
         @(posedge clk); #1;
      end

      // Full frame, DP/EN, mid-dwell write.
      do_reset(1);
      for (int n = 0; n < 96; n++) begin
         if (n == 0)       put(1'b1, 2'd0, 32'h000A5F31);
         else if (n == 40) put(1'b1, 2'd1, 32'h00000004);
         else if (n == 41) put(1'b1, 2'd2, 32'h0000003D);
         else if (n == 57) put(1'b1, 2'd0, 32'h000A8F31);
         else              put(1'b0, 2'd0, 32'h0);
         @(negedge clk);
         if (n < 36 && (n % 6) == 2) begin
            check("frame_sel", {26'h0, seg_sel}, {26'h0, ~(6'd1 << ((n - 2) / 6))});
            check("frame_data", {24'h0, seg_data}, {24'h0, frame_tbl[(n - 2) / 6]});
         end
         if (n == 38) begin
            check("wrap_sel", {26'h0, seg_sel}, 32'h3E);
            check("wrap_data", {24'h0, seg_data}, 32'hF9);
         end
         if (n >= 42 && n <= 47) check("en_off_sel", {26'h0, seg_sel}, 32'h3F);
         if (n == 50) begin
            check("dp_sel", {26'h0, seg_sel}, 32'h3B);
            check("dp_data", {24'h0, seg_data}, 32'h0E);
         end
         if (n == 58 || n == 59) check("middwell_hold", {24'h0, seg_data}, 32'h92);
         if (n == 92) begin
            check("middwell_next_sel", {26'h0, seg_sel}, 32'h37);
            check("middwell_next_data", {24'h0, seg_data}, 32'h80);
         end
         @(posedge clk); #1;
      end

      // Register port: all-ones writes, read-during-write of addr 0.
      for (int a = 0; a < 4; a++) begin
         put(1'b1, 2'(a), 32'hFFFFFFFF);
         @(negedge clk);
         if (a == 0) check("rd_during_wr", bus.rd_data, 32'h000A8F31);
         @(posedge clk); #1;
      end
      for (int a = 0; a < 4; a++) begin
         put(1'b0, 2'(a), 32'h0);
         @(negedge clk);
         case (a)
            0:       check("rd_value", bus.rd_data, 32'h00FFFFFF);
            1:       check("rd_dp", bus.rd_data, 32'h3F);
            2:       check("rd_en", bus.rd_data, 32'h3F);
            default: check("rd_rsvd", bus.rd_data, 32'h0);
         endcase
         @(posedge clk); #1;
      end

      // Reset during digit 4's dwell.
      do_reset(1);
      for (int n = 0; n < 28; n++) begin
         put(n == 0, 2'd0, 32'h00123456);
         if (n == 27) rst = 1'b1;
         @(negedge clk);
         if (n == 27) begin
            check("pre_rst_sel", {26'h0, seg_sel}, 32'h2F);
            check("pre_rst_data", {24'h0, seg_data}, 32'hA4);
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
      put(1'b0, 2'd0, 32'h0);
      @(negedge clk);
      check("rst_sel_off", {26'h0, seg_sel}, 32'h3F);
      check("rst_value", bus.rd_data, 32'h0);
      @(posedge clk); #1;
      put(1'b0, 2'd2, 32'h0);
      @(negedge clk);
      check("rst_en", bus.rd_data, 32'h3F);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_restart_sel", {26'h0, seg_sel}, 32'h3E);
      check("rst_restart_data", {24'h0, seg_data}, 32'hC0);
      @(posedge clk); #1;

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) == 0)
            put(1'b1, 2'($urandom_range(0, 3)), $urandom);
         else
            put(1'b0, 2'($urandom_range(0, 3)), 32'h0);
         rst = ($urandom_range(0, 499) == 0);
         @(posedge clk); #1;
      end
      rst = 1'b0;
      put(1'b0, 2'd0, 32'h0);
      repeat (4) @(posedge clk);
      #1;
      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
